// File: rtl/if_fetch_if.sv
// Instruction ROM read channel: single-outstanding req/ack handshake.
// The fetch stage is the master; the ROM is the slave.
interface if_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              ack;
  logic [DATA_W-1:0] data;

  modport master (
    output req,
    output addr,
    input  ack,
    input  data
  );

  modport slave (
    input  req,
    input  addr,
    output ack,
    output data
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC, single-outstanding ROM fetch, one-entry skid
// buffer for downstream stalls, and branch redirect with wrong-path discard.
module if_fetch #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_stall,
  input  logic              i_branch_flag,
  input  logic [ADDR_W-1:0] i_branch_target,
  if_fetch_if.master        rom,
  output logic              o_if_valid,
  output logic [ADDR_W-1:0] o_if_pc,
  output logic [DATA_W-1:0] o_if_inst
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_FULL = 2'd2,
    S_KILL = 2'd3
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_rom_req;
  logic [ADDR_W-1:0] r_rom_addr;
  logic              r_if_valid;
  logic [ADDR_W-1:0] r_if_pc;
  logic [DATA_W-1:0] r_if_inst;
  logic [ADDR_W-1:0] r_skid_pc;
  logic [DATA_W-1:0] r_skid_inst;

  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_pc_inc;
  logic              w_ack;
  logic              w_take;

  assign w_target = {i_branch_target[ADDR_W-1:2], 2'b00};
  assign w_pc_inc = r_pc + ADDR_W'(3'd4);
  assign w_ack    = r_rom_req & rom.ack;
  // Output register may accept a new instruction when not held, or when it only holds a bubble
  assign w_take   = ~i_stall | ~r_if_valid;

  // Fetch FSM; ROM request/address and the IF/ID outputs are all registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_BOOT;
      r_pc        <= RESET_PC;
      r_rom_req   <= 1'b0;
      r_rom_addr  <= '0;
      r_if_valid  <= 1'b0;
      r_if_pc     <= '0;
      r_if_inst   <= '0;
      r_skid_pc   <= '0;
      r_skid_inst <= '0;
    end else if (i_branch_flag) begin
      r_pc       <= w_target;
      r_if_valid <= 1'b0;
      r_if_inst  <= '0;
      // An unacked request must run to completion with its original address
      if (r_rom_req && !rom.ack) begin
        r_state <= S_KILL;
      end else begin
        r_state    <= S_REQ;
        r_rom_req  <= 1'b1;
        r_rom_addr <= w_target;
      end
    end else begin
      case (r_state)
        S_BOOT: begin
          r_state    <= S_REQ;
          r_rom_req  <= 1'b1;
          r_rom_addr <= r_pc;
          if (!i_stall) begin
            r_if_valid <= 1'b0;
            r_if_inst  <= '0;
          end
        end
        S_REQ: begin
          if (w_ack) begin
            r_pc <= w_pc_inc;
            if (w_take) begin
              r_if_valid <= 1'b1;
              r_if_pc    <= r_pc;
              r_if_inst  <= rom.data;
              r_rom_addr <= w_pc_inc;
            end else begin
              r_skid_pc   <= r_pc;
              r_skid_inst <= rom.data;
              r_state     <= S_FULL;
              r_rom_req   <= 1'b0;
            end
          end else if (!i_stall) begin
            r_if_valid <= 1'b0;
            r_if_inst  <= '0;
          end
        end
        S_FULL: begin
          if (!i_stall) begin
            r_if_valid <= 1'b1;
            r_if_pc    <= r_skid_pc;
            r_if_inst  <= r_skid_inst;
            r_state    <= S_REQ;
            r_rom_req  <= 1'b1;
            r_rom_addr <= r_pc;
          end
        end
        S_KILL: begin
          if (!i_stall) begin
            r_if_valid <= 1'b0;
            r_if_inst  <= '0;
          end
          // Wrong-path data is dropped; the redirect target is issued next
          if (w_ack) begin
            r_state    <= S_REQ;
            r_rom_addr <= r_pc;
          end
        end
        default: begin
          r_state   <= S_BOOT;
          r_rom_req <= 1'b0;
        end
      endcase
    end
  end

  assign rom.req    = r_rom_req;
  assign rom.addr   = r_rom_addr;
  assign o_if_valid = r_if_valid;
  assign o_if_pc    = r_if_pc;
  assign o_if_inst  = r_if_inst;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: zero-wait and 3-cycle ROM, stall/skid,
// branch kill, branch over a full buffer, reset mid-wait, and PC wrap.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_flag;
  logic [31:0] branch_target;

  logic        v1, v2;
  logic [31:0] pc1, pc2, inst1, inst2;

  int lat;
  int cnt;
  int n_cmp;
  int n_bad;

  if_fetch_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
  if_fetch_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();

  // ROM 1: ack arrives lat cycles after req rises (lat=0 means same cycle)
  assign bus1.ack  = bus1.req && (cnt == lat);
  assign bus1.data = bus1.addr ^ 32'hA5A5_0000;

  always @(posedge clk) begin
    if (!bus1.req || bus1.ack) cnt <= 0;
    else                       cnt <= cnt + 1;
  end

  // ROM 2: always zero-wait
  assign bus2.ack  = bus2.req;
  assign bus2.data = bus2.addr ^ 32'hA5A5_0000;

  if_fetch #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .i_stall(stall), .i_branch_flag(branch_flag),
    .i_branch_target(branch_target), .rom(bus1),
    .o_if_valid(v1), .o_if_pc(pc1), .o_if_inst(inst1)
  );

  if_fetch #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst(rst), .i_stall(stall), .i_branch_flag(branch_flag),
    .i_branch_target(branch_target), .rom(bus2),
    .o_if_valid(v2), .o_if_pc(pc2), .o_if_inst(inst2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    lat = 0;
    rst = 1'b1;
    stall = 1'b0;
    branch_flag = 1'b0;
    branch_target = 32'h0;

    // Reset state, zero-wait streaming
    tick();
    check("rst_valid", {31'd0, v1}, 32'd0);
    check("rst_pc", pc1, 32'd0);
    check("rst_inst", inst1, 32'd0);
    check("rst_req", {31'd0, bus1.req}, 32'd0);
    check("rst_addr", bus1.addr, 32'd0);
    rst = 1'b0;
    tick();
    check("boot_req", {31'd0, bus1.req}, 32'd1);
    check("boot_addr", bus1.addr, 32'd0);
    check("boot_valid", {31'd0, v1}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("zw_valid", {31'd0, v1}, 32'd1);
      check("zw_pc", pc1, 32'(4 * k));
      check("zw_inst", inst1, 32'(4 * k) ^ 32'hA5A5_0000);
    end

    // Stall for 5 cycles: output frozen at 0xC, one fetch buffered
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", {31'd0, v1}, 32'd1);
      check("stall_pc", pc1, 32'h0000_000C);
      check("stall_req", {31'd0, bus1.req}, 32'd0);
    end
    stall = 1'b0;
    tick();
    check("unstall_pc", pc1, 32'h0000_0010);
    check("unstall_inst", inst1, 32'hA5A5_0010);
    check("unstall_req", {31'd0, bus1.req}, 32'd1);
    check("unstall_addr", bus1.addr, 32'h0000_0014);
    tick();
    check("unstall_pc2", pc1, 32'h0000_0014);
    tick();
    check("unstall_pc3", pc1, 32'h0000_0018);

    // 3-cycle ROM latency
    rst = 1'b1;
    lat = 3;
    tick();
    rst = 1'b0;
    tick();
    check("l3_req", {31'd0, bus1.req}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("l3_wait_addr", bus1.addr, 32'd0);
      check("l3_wait_req", {31'd0, bus1.req}, 32'd1);
      check("l3_wait_valid", {31'd0, v1}, 32'd0);
    end
    tick();
    check("l3_pc0", pc1, 32'd0);
    check("l3_valid0", {31'd0, v1}, 32'd1);
    check("l3_inst0", inst1, 32'hA5A5_0000);
    for (int k = 1; k < 4; k++) begin
      for (int i = 0; i < 3; i++) begin
        tick();
        check("l3_gap_valid", {31'd0, v1}, 32'd0);
        check("l3_gap_inst", inst1, 32'd0);
        check("l3_gap_addr", bus1.addr, 32'(4 * k));
      end
      tick();
      check("l3_valid", {31'd0, v1}, 32'd1);
      check("l3_pc", pc1, 32'(4 * k));
    end

    // Branch while request to 0x10 is in flight
    tick();
    check("br_pre_valid", {31'd0, v1}, 32'd0);
    branch_flag = 1'b1;
    branch_target = 32'h0000_0103;
    tick();
    branch_flag = 1'b0;
    branch_target = 32'h0;
    check("kill_valid", {31'd0, v1}, 32'd0);
    check("kill_inst", inst1, 32'd0);
    check("kill_req", {31'd0, bus1.req}, 32'd1);
    check("kill_addr", bus1.addr, 32'h0000_0010);
    tick();
    check("kill_addr2", bus1.addr, 32'h0000_0010);
    tick();
    check("kill_done_addr", bus1.addr, 32'h0000_0100);
    check("kill_done_valid", {31'd0, v1}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("kill_bubble", {31'd0, v1}, 32'd0);
    end
    tick();
    check("tgt_valid", {31'd0, v1}, 32'd1);
    check("tgt_pc", pc1, 32'h0000_0100);
    check("tgt_inst", inst1, 32'hA5A5_0100);

    // Fill skid buffer, then branch together with stall
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fill_wait_req", {31'd0, bus1.req}, 32'd1);
      check("fill_wait_pc", pc1, 32'h0000_0100);
    end
    tick();
    check("full_req", {31'd0, bus1.req}, 32'd0);
    check("full_pc", pc1, 32'h0000_0100);
    check("full_valid", {31'd0, v1}, 32'd1);
    branch_flag = 1'b1;
    branch_target = 32'h0000_0200;
    tick();
    branch_flag = 1'b0;
    stall = 1'b0;
    check("brfull_valid", {31'd0, v1}, 32'd0);
    check("brfull_inst", inst1, 32'd0);
    check("brfull_req", {31'd0, bus1.req}, 32'd1);
    check("brfull_addr", bus1.addr, 32'h0000_0200);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("brfull_bubble", {31'd0, v1}, 32'd0);
    end
    tick();
    check("brfull_tgt_pc", pc1, 32'h0000_0200);
    check("brfull_tgt_inst", inst1, 32'hA5A5_0200);

    // Reset mid-wait
    tick();
    check("midwait_req", {31'd0, bus1.req}, 32'd1);
    check("midwait_addr", bus1.addr, 32'h0000_0204);
    rst = 1'b1;
    tick();
    check("rst2_valid", {31'd0, v1}, 32'd0);
    check("rst2_pc", pc1, 32'd0);
    check("rst2_inst", inst1, 32'd0);
    check("rst2_req", {31'd0, bus1.req}, 32'd0);
    check("rst2_addr", bus1.addr, 32'd0);
    check("wrap_rst_req", {31'd0, bus2.req}, 32'd0);
    check("wrap_rst_valid", {31'd0, v2}, 32'd0);
    rst = 1'b0;

    // PC wrap from RESET_PC=FFFF_FFF8
    tick();
    check("wrap_boot_addr", bus2.addr, 32'hFFFF_FFF8);
    tick();
    check("wrap_pc0", pc2, 32'hFFFF_FFF8);
    check("wrap_inst0", inst2, 32'h5A5A_FFF8);
    tick();
    check("wrap_pc1", pc2, 32'hFFFF_FFFC);
    check("wrap_inst1", inst2, 32'h5A5A_FFFC);
    tick();
    check("wrap_pc2", pc2, 32'h0000_0000);
    check("wrap_valid2", {31'd0, v2}, 32'd1);

    // Branch concurrent with ack: acked data dropped, target issued next
    branch_flag = 1'b1;
    branch_target = 32'h0000_0043;
    tick();
    branch_flag = 1'b0;
    check("brack_valid", {31'd0, v2}, 32'd0);
    check("brack_addr", bus2.addr, 32'h0000_0040);
    tick();
    check("brack_tgt_valid", {31'd0, v2}, 32'd1);
    check("brack_tgt_pc", pc2, 32'h0000_0040);
    check("brack_tgt_inst", inst2, 32'hA5A5_0040);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
Instruction-fetch stage that produces the (pc, instruction) pair consumed by the IF/ID pipeline register. It holds the PC and issues single-outstanding requests to a variable-latency instruction ROM over a req/ack handshake. It absorbs pipeline stalls with a one-entry skid buffer and redirects on branches, discarding wrong-path fetches.

Parameters:
ADDR_W, 32, width of PC and ROM address
DATA_W, 32, instruction width
RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
stall  input  1  downstream hold: IF/ID must not advance; outputs hold
branch_flag  input  1  one-cycle redirect request from ID
branch_target  input  ADDR_W  redirect address; bits [1:0] ignored and forced to 0
rom_req  output  1  instruction read request
rom_addr  output  ADDR_W  read address; stable while rom_req=1
rom_ack  input  1  read complete; rom_data valid this cycle; may assert in the same cycle rom_req rises
rom_data  input  DATA_W  instruction returned with rom_ack
if_valid  output  1  if_pc/if_inst hold a real instruction; 0 means bubble
if_pc  output  ADDR_W  address of the delivered instruction
if_inst  output  DATA_W  delivered instruction; 0 (NOP) when if_valid=0

Behaviour:
- Reset (rst=1 at an edge, overrides all inputs, including mid-request): pc_q=RESET_PC, state=BOOT, rom_req=0, rom_addr=0, if_valid=0, if_pc=0, if_inst=0, skid buffer empty, kill flag clear. Outstanding ROM transactions are abandoned; the ROM must tolerate a dropped request.
- States:
  - BOOT: one cycle, no request. Then goes to REQ.
  - REQ: rom_req=1, rom_addr=pc_q.
  - FULL: the skid buffer is occupied and the output is stalled. rom_req=0.
  - KILL: a redirected request is still in flight. rom_req=1 and the old address is kept until ack.
- REQ with rom_ack=1, not killed, no branch:
  - If stall=0 or if_valid=0, the output register loads if_pc=pc_q, if_inst=rom_data, if_valid=1 at the next edge.
  - Otherwise (stall=1 and if_valid=1), the data goes into the skid buffer and the state moves to FULL.
  - In both cases pc_q<=pc_q+4 (modulo 2^ADDR_W, so 32'hFFFF_FFFC wraps to 0).
  - Then returns to REQ, or stays in FULL. rom_req deasserts for at most zero cycles when no stall: back-to-back acks give 1 instr/cycle.
- Stall with no ack pending: the output register holds its value unchanged. Requests continue until the buffer fills. At most one instruction is buffered and at most one is in flight.
- FULL and stall falls to 0: the buffer moves to the output register at the next edge, the buffer empties, and the state returns to REQ, which reasserts rom_req in that same next cycle.
- Output, stall=0 and nothing new to deliver: at the next edge if_valid<=0 and if_inst<=0, with if_pc holding its value (bubble).
- branch_flag=1 (priority over stall, ack and buffer):
  - At the next edge pc_q<=target&~3, if_valid<=0, if_inst<=0, and the buffer is emptied.
  - If a request is in flight with no ack this cycle, go to KILL. Otherwise go to REQ, issuing target the next cycle.
  - Branch concurrent with ack: the acked data is discarded.
- KILL: on rom_ack, discard the data and go to REQ with rom_addr=pc_q (the target). A second branch_flag in KILL updates pc_q and stays in KILL.
- Latency: from rom_ack to visible if_valid is 1 cycle. From branch_flag to first target rom_req is 1 cycle, or ack+1 if in KILL.
- Invariant: rom_addr and rom_req never change while rom_req=1 and rom_ack=0, except under rst.

Test Plan:
- Reset then zero-wait ROM (ack combinational with req, data=addr^32'hA5A5_0000) -> if_valid first high 2 cycles after rst falls with if_pc=0, then if_pc=4, 8, 12 on consecutive cycles, all if_inst matching.
- ROM ack latency 3 cycles -> rom_addr stable during each wait; if_pc sequence 0, 4, 8 spaced 4 cycles; if_valid=0 between deliveries.
- Hold stall=1 for 5 cycles during streaming -> outputs frozen at the stalled pc; exactly one extra fetch buffered and rom_req low afterward; on release, next pcs are delivered in order with none lost or duplicated.
- branch_flag with target 32'h0000_0103 while a 3-cycle request to 0x10 is in flight -> the 0x10 data is never delivered, next rom_addr=0x100, and if_pc=0x100 is the first valid output after the bubble.
- branch_flag and stall high in the same cycle with the buffer full -> if_valid=0 next cycle, buffer discarded, fetch resumes at the target.
- RESET_PC=32'hFFFF_FFF8 -> if_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000. rst asserted mid-wait -> all outputs 0 and rom_req=0 next cycle.
